duty_cycle_meter: RTL and testbench

Synthesizable measurement end for the clock-generator family: samples an asynchronous square wave on the system clock and reports its period, high time and duty cycle in integer percent. It sits beside each generated clock as an on-chip monitor, gated by the same `enable` that starts the generator. It also flags stuck-at waveforms and, optionally, checks the measured duty against a target.

---
 rtl/duty_meter_pkg.sv | 7 +
 rtl/seq_divider.sv | 50 +++++
 rtl/duty_cycle_meter.sv | 170 +++++++++++++++++
 tb/tb_duty_cycle_meter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_meter_pkg.sv
// duty_meter_pkg: FSM states and shared constants for duty_cycle_meter.
package duty_meter_pkg;
    typedef enum logic [1:0] {IDLE, ARM, MEAS, DIV} state_t;
    localparam int DIV_STEPS = 7;
    localparam int PCT_W = 7;
    localparam int PCT = 100;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle, start/busy/done handshake.
// The quotient must fit in QW bits; DW must be at least VW+QW-1.
module seq_divider #(
    parameter int DW = 23,
    parameter int VW = 16,
    parameter int QW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int CW = $clog2(QW + 1);

    logic [DW-1:0] rem, dsh;
    logic [CW-1:0] cnt;
    logic          ge;

    assign busy = cnt != '0;
    assign ge   = rem >= dsh;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rem      <= '0;
            dsh      <= '0;
            cnt      <= '0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= busy && cnt == CW'(1) && !abort && !start;
            if (abort)
                cnt <= '0;
            else if (start) begin
                rem      <= dividend;
                dsh      <= DW'(divisor) << (QW - 1);
                quotient <= '0;
                cnt      <= CW'(QW);
            end else if (busy) begin
                rem      <= ge ? rem - dsh : rem;
                quotient <= {quotient[QW-2:0], ge};
                dsh      <= dsh >> 1;
                cnt      <= cnt - CW'(1);
            end
        end
endmodule

// File: rtl/duty_cycle_meter.sv
// duty_cycle_meter: measures period, high time and duty percent of an async square wave.
// Define DUTY_CHECK_EN to add the duty_ok window comparator against DUTY +/- TOL.
module duty_cycle_meter
    import duty_meter_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DUTY  = 50,
    parameter int TOL   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [PCT_W-1:0] duty_pct,
    output logic             dc_valid,
    output logic             overrun,
    output logic             stuck,
    output logic             stuck_level
`ifdef DUTY_CHECK_EN
    ,
    output logic             duty_ok
`endif
);
    localparam int DW = CNT_W + PCT_W;
    localparam logic [CNT_W-1:0] SAT_M1 = {{(CNT_W - 1){1'b1}}, 1'b0};

    if (DUTY < 0 || DUTY > PCT || TOL < 0) begin : g_cfg_err
        $error("duty_cycle_meter: DUTY and TOL must be percentages");
    end

    state_t            state, state_d;
    logic [1:0]        rst_sync;
    logic              arst_n;
    logic [2:0]        sh;
    logic              sync, rise, fall;
    logic [CNT_W-1:0]  per_cnt, hi_cnt, cap_per, cap_hi;
    logic [DIV_STEPS-1:0] quo;
    logic              start, restart, clr, load, ovr, sat, abort, div_busy, div_done;

    // Assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign arst_n = rst_sync[1];

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) sh <= '0;
        else sh <= {sh[1:0], sig_in};
    assign sync = sh[1];
    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) state <= IDLE;
        else state <= state_d;

    always_comb begin
        state_d = state;
        start   = 1'b0;
        restart = 1'b0;
        clr     = 1'b0;
        load    = 1'b0;
        ovr     = 1'b0;
        sat     = 1'b0;
        abort   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            clr     = 1'b1;
            abort   = div_busy;
        end else begin
            case (state)
                IDLE: begin
                    clr     = 1'b1;
                    state_d = ARM;
                end
                ARM: if (rise) begin
                    restart = 1'b1;
                    state_d = MEAS;
                end
                MEAS:
                    if (rise) begin
                        start   = 1'b1;
                        restart = 1'b1;
                        state_d = DIV;
                    end else if (per_cnt == SAT_M1) begin
                        sat     = 1'b1;
                        state_d = ARM;
                    end
                DIV: begin
                    // A rise on the completion cycle is a legal minimum-length period.
                    load    = div_done;
                    state_d = div_done ? MEAS : DIV;
                    if (rise) begin
                        restart = 1'b1;
                        start   = div_done;
                        ovr     = !div_done;
                        state_d = div_done ? DIV : state_d;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (clr) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (restart) begin
            per_cnt <= '0;
            hi_cnt  <= CNT_W'(sync);
        end else if (state == MEAS || state == DIV) begin
            per_cnt <= per_cnt + CNT_W'(per_cnt != '1);
            hi_cnt  <= hi_cnt + CNT_W'(sync && hi_cnt != '1);
        end

    seq_divider #(.DW(DW), .VW(CNT_W), .QW(DIV_STEPS)) u_div (
        .clk      (clk),
        .rst_n    (arst_n),
        .start    (start),
        .abort    (abort),
        .dividend (DW'(hi_cnt) * DW'(PCT)),
        .divisor  (per_cnt + CNT_W'(1)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo)
    );

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            cap_per     <= '0;
            cap_hi      <= '0;
            period      <= '0;
            high_time   <= '0;
            duty_pct    <= '0;
            dc_valid    <= 1'b0;
            overrun     <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            dc_valid <= load;
            overrun  <= ovr;
            if (start) begin
                cap_per <= per_cnt + CNT_W'(1);
                cap_hi  <= hi_cnt;
            end
            if (load) begin
                period    <= cap_per;
                high_time <= cap_hi;
                duty_pct  <= quo;
            end
            if (sat) begin
                stuck       <= 1'b1;
                stuck_level <= sync;
            end else if (!enable || rise || fall)
                stuck <= 1'b0;
        end

`ifdef DUTY_CHECK_EN
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) duty_ok <= 1'b0;
        else if (sat) duty_ok <= 1'b0;
        else if (load) duty_ok <= int'(quo) >= DUTY - TOL && int'(quo) <= DUTY + TOL;
`endif
endmodule

// File: tb/tb_duty_cycle_meter.sv
// tb_duty_cycle_meter: scenario tasks checking duty_cycle_meter against an arithmetic model.
// Expected reports are derived from the driven waveform: period P, high H, duty floor(100H/P).
module tb_duty_cycle_meter;
    typedef struct {
        int p;
        int h;
        int d;
        bit ok;
    } rep_t;

`ifdef DUTY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, sig_in = 1'b0;
    logic [7:0] period, high_time;
    logic [6:0] duty_pct;
    logic       dc_valid, overrun, stuck, stuck_level, dok;

    int   n_cmp = 0, n_bad = 0, ovr_cnt = 0;
    rep_t obs_q[$];
    int   exp_p[$], exp_h[$];

    duty_cycle_meter #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sig_in      (sig_in),
        .period      (period),
        .high_time   (high_time),
        .duty_pct    (duty_pct),
        .dc_valid    (dc_valid),
        .overrun     (overrun),
        .stuck       (stuck),
        .stuck_level (stuck_level)
`ifdef DUTY_CHECK_EN
        ,
        .duty_ok     (dok)
`endif
    );
`ifndef DUTY_CHECK_EN
    assign dok = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dc_valid) obs_q.push_back('{int'(period), int'(high_time), int'(duty_pct), dok});
        if (overrun) ovr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic hold(input logic v, input int n);
        sig_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic rearm();
        enable = 1'b0;
        hold(1'b0, 3);
        enable = 1'b1;
        hold(1'b0, 4);
    endtask

    // First rise arms; each queued period then ends on the next rise.
    task automatic drive_stream();
        for (int k = 0; k < exp_p.size(); k++) begin
            hold(1'b1, exp_h[k]);
            hold(1'b0, exp_p[k] - exp_h[k]);
        end
        hold(1'b1, 14);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        hold(1'b1, 4);
        n_cmp++;
        if ({period, high_time, duty_pct, dc_valid, overrun, stuck, stuck_level, dok} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got p=%0d h=%0d d=%0d v=%b o=%b s=%b sl=%b ok=%b, expected all 0",
                     period, high_time, duty_pct, dc_valid, overrun, stuck, stuck_level, dok);
        end
        sig_in = 1'b0;
        rst_n  = 1'b1;
        hold(1'b0, 4);
    endtask

    task automatic test_duty(input string name, input int n, input int p, input int h);
        int   base, ob, ep, eh, ed;
        rep_t r;
        base = obs_q.size();
        ob   = ovr_cnt;
        exp_p.delete();
        exp_h.delete();
        for (int k = 0; k < n; k++) begin
            ep = (p != 0) ? p : int'($urandom_range(40, 8));
            eh = (p != 0) ? h : int'($urandom_range(ep - 1, 1));
            exp_p.push_back(ep);
            exp_h.push_back(eh);
        end
        rearm();
        drive_stream();
        n_cmp++;
        if (obs_q.size() - base !== n || ovr_cnt - ob !== 0) begin
            n_bad++;
            $display("FAIL %s count: got %0d reports / %0d overruns, expected %0d / 0",
                     name, obs_q.size() - base, ovr_cnt - ob, n);
        end
        for (int k = 0; k < n && base + k < obs_q.size(); k++) begin
            r  = obs_q[base + k];
            ed = exp_h[k] * 100 / exp_p[k];
            n_cmp++;
            if (r.p !== exp_p[k] || r.h !== exp_h[k] || r.d !== ed || r.ok !== (CHK && ed >= 45 && ed <= 55)) begin
                n_bad++;
                $display("FAIL %s report %0d: got p=%0d h=%0d d=%0d ok=%b, expected p=%0d h=%0d d=%0d ok=%b",
                         name, k, r.p, r.h, r.d, r.ok, exp_p[k], exp_h[k], ed, CHK && ed >= 45 && ed <= 55);
            end
        end
    endtask

    // Period 6 is below the minimum: every second rise lands in the division and is dropped.
    task automatic test_overrun();
        int   base, ob;
        rep_t r;
        base = obs_q.size();
        ob   = ovr_cnt;
        exp_p.delete();
        exp_h.delete();
        for (int k = 0; k < 7; k++) begin
            exp_p.push_back(6);
            exp_h.push_back(3);
        end
        rearm();
        drive_stream();
        n_cmp++;
        if (obs_q.size() - base !== 4 || ovr_cnt - ob !== 3) begin
            n_bad++;
            $display("FAIL overrun count: got %0d reports / %0d overruns, expected 4 / 3",
                     obs_q.size() - base, ovr_cnt - ob);
        end
        for (int k = base; k < obs_q.size(); k++) begin
            r = obs_q[k];
            n_cmp++;
            if (r.p !== 6 || r.h !== 3 || r.d !== 50) begin
                n_bad++;
                $display("FAIL overrun report: got p=%0d h=%0d d=%0d, expected p=6 h=3 d=50", r.p, r.h, r.d);
            end
        end
    endtask

    task automatic test_stuck();
        int   base;
        rep_t r;
        base = obs_q.size();
        rearm();
        hold(1'b1, 200);
        n_cmp++;
        if (stuck !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_early: got stuck=%b, expected 0", stuck);
        end
        hold(1'b1, 100);
        n_cmp++;
        if (stuck !== 1'b1 || stuck_level !== 1'b1 || obs_q.size() !== base) begin
            n_bad++;
            $display("FAIL stuck_set: got stuck=%b level=%b reports=%0d, expected 1 1 0",
                     stuck, stuck_level, obs_q.size() - base);
        end
        hold(1'b0, 5);
        n_cmp++;
        if (stuck !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_clear: got stuck=%b, expected 0", stuck);
        end
        hold(1'b1, 4);
        hold(1'b0, 6);
        hold(1'b1, 14);
        n_cmp++;
        if (obs_q.size() - base !== 1) begin
            n_bad++;
            $display("FAIL stuck_recover count: got %0d reports, expected 1", obs_q.size() - base);
        end else begin
            r = obs_q[base];
            n_cmp++;
            if (r.p !== 10 || r.h !== 4 || r.d !== 40) begin
                n_bad++;
                $display("FAIL stuck_recover report: got p=%0d h=%0d d=%0d, expected 10 4 40", r.p, r.h, r.d);
            end
        end
    endtask

    task automatic test_abort();
        int base;
        test_duty("abort_pre", 1, 12, 3);
        base = obs_q.size();
        rearm();
        hold(1'b1, 5);
        hold(1'b0, 11);
        hold(1'b1, 6);
        enable = 1'b0;
        hold(1'b1, 15);
        n_cmp++;
        if (obs_q.size() !== base || period !== 8'd12 || high_time !== 8'd3 || duty_pct !== 7'd25) begin
            n_bad++;
            $display("FAIL abort_hold: got reports=%0d p=%0d h=%0d d=%0d, expected 0 12 3 25",
                     obs_q.size() - base, period, high_time, duty_pct);
        end
        test_duty("abort_post", 2, 10, 7);
    endtask

    task automatic test_reset_mid();
        int   base;
        rep_t r;
        rearm();
        hold(1'b1, 5);
        hold(1'b0, 11);
        hold(1'b1, 5);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({period, high_time, duty_pct, dc_valid, overrun, stuck, stuck_level, dok} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got p=%0d h=%0d d=%0d v=%b o=%b s=%b, expected all 0",
                     period, high_time, duty_pct, dc_valid, overrun, stuck);
        end
        @(negedge clk);
        hold(1'b0, 3);
        rst_n = 1'b1;
        base  = obs_q.size();
        hold(1'b0, 6);
        hold(1'b1, 4);
        hold(1'b0, 8);
        n_cmp++;
        if (obs_q.size() !== base) begin
            n_bad++;
            $display("FAIL reset_rearm early: got %0d reports, expected 0", obs_q.size() - base);
        end
        hold(1'b1, 14);
        n_cmp++;
        if (obs_q.size() - base !== 1) begin
            n_bad++;
            $display("FAIL reset_rearm count: got %0d reports, expected 1", obs_q.size() - base);
        end else begin
            r = obs_q[base];
            n_cmp++;
            if (r.p !== 12 || r.h !== 4 || r.d !== 33) begin
                n_bad++;
                $display("FAIL reset_rearm report: got p=%0d h=%0d d=%0d, expected 12 4 33", r.p, r.h, r.d);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_duty("duty25", 4, 8, 2);
        test_duty("duty50", 3, 20, 10);
        test_duty("duty75", 3, 20, 15);
        test_duty("random", 12, 0, 0);
        test_overrun();
        test_stuck();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
